// File: rtl/polar_encoder.sv
// Serial-in, parallel-out polar encoder: loads K info bits into non-frozen u positions, runs LOG_N butterfly stages, presents cw.
// Latency: LOG_N cycles from K-th accept to out_valid. cw is held until the out handshake, and no input is accepted until then.
module polar_encoder #(
  parameter int                       LOG_N     = 3,
  parameter logic [(2**LOG_N)-1:0]    INFO_MASK = 8'hE8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_bit,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [(2**LOG_N)-1:0]       cw
);

  localparam int N  = 2**LOG_N;
  localparam int K  = $countones(INFO_MASK);
  localparam int CW = (K + 1 > 1) ? $clog2(K + 1) : 1;
  localparam int SW = $clog2(LOG_N + 1);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_ENC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  if (K < 1 || LOG_N < 1 || LOG_N > 10) begin : g_param_err
    $error("polar_encoder: need K >= 1 and LOG_N in 1..10");
  end

  // Number of information positions strictly below idx: the accept order of that position.
  function automatic int rank_of(input int idx);
    int r;
    r = 0;
    for (int j = 0; j < idx; j++) begin
      if (INFO_MASK[j]) r++;
    end
    return r;
  endfunction

  logic [1:0]    state;
  logic [N-1:0]  v;
  logic [CW-1:0] info_cnt;
  logic [SW-1:0] stg_cnt;

  assign in_ready  = rst_n && (state == S_LOAD);
  assign out_valid = (state == S_OUT);
  assign cw        = (state == S_OUT) ? v : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_LOAD;
      v        <= '0;
      info_cnt <= '0;
      stg_cnt  <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++) begin
              if (INFO_MASK[i] && (info_cnt == CW'(rank_of(i)))) v[i] <= in_bit;
            end
            info_cnt <= info_cnt + 1'b1;
            if (info_cnt == CW'(K - 1)) state <= S_ENC;
          end
        end
        S_ENC: begin
          // In-place butterfly: each stage folds the upper half of every 2^(s+1) block into the lower half.
          for (int s = 0; s < LOG_N; s++) begin
            if (stg_cnt == SW'(s)) begin
              for (int i = 0; i < N; i++) begin
                if (((i >> s) & 1) == 0) v[i] <= v[i] ^ v[i + (1 << s)];
              end
            end
          end
          if (stg_cnt == SW'(LOG_N - 1)) begin
            stg_cnt <= '0;
            state   <= S_OUT;
          end else begin
            stg_cnt <= stg_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state    <= S_LOAD;
            v        <= '0;
            info_cnt <= '0;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_polar_encoder.sv
// Directed bench for polar_encoder with LOG_N=3, INFO_MASK=8'hE8 (info positions 3,5,6,7).
module tb_polar_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] cw;

  int errors = 0;
  int checks = 0;

  polar_encoder #(.LOG_N(3), .INFO_MASK(8'hE8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cw        (cw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bits;   // bits[k] is the k-th bit sent (k=0 -> u3)
    logic [7:0] exp_cw;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends four bits with in_valid held high; returns once the last is accepted.
  task automatic send_frame(input logic [3:0] bits);
    for (int k = 0; k < 4; k++) begin
      int t;
      t = 0;
      in_valid = 1'b1;
      in_bit   = bits[k];
      while (!in_ready && t < 50) begin
        tick();
        t++;
      end
      if (t >= 50) check("in_ready_timeout", 32'd0, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  // Same as send_frame, but in_valid is random each cycle.
  task automatic send_frame_rand(input logic [3:0] bits);
    int k;
    int t;
    k = 0;
    t = 0;
    while (k < 4 && t < 200) begin
      in_valid = 1'($urandom_range(0, 1));
      in_bit   = in_valid ? bits[k] : 1'($urandom_range(0, 1));
      if (in_valid && in_ready) k++;
      tick();
      t++;
    end
    if (k < 4) check("rand_send_timeout", 32'(k), 32'd4);
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  // Counts edges from the current point until out_valid rises.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    vecs[0] = '{4'b0001, 8'h0F};
    vecs[1] = '{4'b0010, 8'h33};
    vecs[2] = '{4'b1000, 8'hFF};
    vecs[3] = '{4'b0100, 8'h55};
    vecs[4] = '{4'b1111, 8'h96};
    vecs[5] = '{4'b0011, 8'h3C};
    vecs[6] = '{4'b1100, 8'hAA};
    vecs[7] = '{4'b0101, 8'h5A};
    vecs[8] = '{4'b0000, 8'h00};

    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cw", 32'(cw), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int n = 0; n < 9; n++) begin
      send_frame(vecs[n].bits);
      check("cw_before_out", 32'(cw), 32'd0);
      wait_out(lat);
      check("latency", 32'(lat), 32'd3);
      check($sformatf("cw_vec%0d", n), 32'(cw), 32'(vecs[n].exp_cw));
      check("in_ready_in_out", 32'(in_ready), 32'd0);
      take_output();
      check("out_valid_after_take", 32'(out_valid), 32'd0);
      check("cw_after_take", 32'(cw), 32'd0);
      check("in_ready_after_take", 32'(in_ready), 32'd1);
    end

    // Backpressure: hold output 5 cycles while in_valid is asserted and ignored.
    send_frame(4'b1111);
    wait_out(lat);
    in_valid = 1'b1; in_bit = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("hold_cw", 32'(cw), 32'h96);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0; in_bit = 1'b0;
    take_output();
    send_frame(4'b0001);
    wait_out(lat);
    check("after_hold_cw", 32'(cw), 32'h0F);
    take_output();

    // Random in_valid, back-to-back frames with out_ready held high.
    out_ready = 1'b1;
    send_frame_rand(4'b1111);
    wait_out(lat);
    check("rand_cw0", 32'(cw), 32'h96);
    tick();
    send_frame_rand(4'b0001);
    wait_out(lat);
    check("rand_cw1", 32'(cw), 32'h0F);
    tick();
    check("rand_out_valid_done", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Reset during ENC discards the frame.
    send_frame(4'b1111);
    tick();
    rst_n = 1'b0;
    #1;
    check("enc_rst_out_valid", 32'(out_valid), 32'd0);
    check("enc_rst_cw", 32'(cw), 32'd0);
    check("enc_rst_in_ready", 32'(in_ready), 32'd0);
    tick(); tick();
    check("enc_rst_hold_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    send_frame(4'b0010);
    wait_out(lat);
    check("enc_rst_latency", 32'(lat), 32'd3);
    check("enc_rst_cw", 32'(cw), 32'h33);
    take_output();
    tick(); tick();
    check("enc_rst_single_out", 32'(out_valid), 32'd0);

    // Reset mid-LOAD: two bits sent, then discarded.
    in_valid = 1'b1; in_bit = 1'b1;
    tick(); tick();
    in_valid = 1'b0; in_bit = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(4'b1000);
    wait_out(lat);
    check("load_rst_cw", 32'(cw), 32'hFF);
    check("load_rst_latency", 32'(lat), 32'd3);

    // Reset mid-OUT.
    rst_n = 1'b0;
    #1;
    check("out_rst_out_valid", 32'(out_valid), 32'd0);
    check("out_rst_cw", 32'(cw), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(4'b0100);
    wait_out(lat);
    check("out_rst_next_cw", 32'(cw), 32'h55);
    take_output();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
